// File: rtl/pong_game_render.sv
// pong_game_render
// Pixel-generation stage that sits behind the LCD timing generator. It runs the
// pong game once per frame (ball motion, wall/paddle bounces, paddle movement,
// scoring) and produces registered RGB565 one cycle after each X/Y/LCD_DEN.
//
// Ports
//   CLK                   pixel clock
//   RST_IN                synchronous active-high reset
//   LCD_DEN               active-area enable, qualifies X/Y
//   LCD_VSYNC             vertical sync (low during pulse); its rising edge is the frame tick
//   X, Y                  active-area column/row
//   BTN_{L,R}_{UP,DN}     paddle buttons, active-high, synchronous to CLK
//   RED/GREEN/BLUE        registered pixel colour
//   SCORE_L, SCORE_R      decimal score digits (0..9, wrap to 0)
module pong_game_render #(
    parameter int LCD_WIDTH     = 480,
    parameter int LCD_HEIGHT    = 280,
    parameter int BALL_SIZE     = 8,
    parameter int PADDLE_W      = 6,
    parameter int PADDLE_H      = 48,
    parameter int PADDLE_MARGIN = 8,
    parameter int PADDLE_SPEED  = 4,
    parameter int BALL_SPEED    = 2,
    parameter int SERVE_FRAMES  = 60
) (
    input  logic        CLK,
    input  logic        RST_IN,
    input  logic        LCD_DEN,
    input  logic        LCD_VSYNC,
    input  logic [10:0] X,
    input  logic [10:0] Y,
    input  logic        BTN_L_UP,
    input  logic        BTN_L_DN,
    input  logic        BTN_R_UP,
    input  logic        BTN_R_DN,
    output logic [4:0]  RED,
    output logic [5:0]  GREEN,
    output logic [4:0]  BLUE,
    output logic [3:0]  SCORE_L,
    output logic [3:0]  SCORE_R
);
    localparam logic [10:0] BX_C     = 11'((LCD_WIDTH - BALL_SIZE) / 2);
    localparam logic [10:0] BY_C     = 11'((LCD_HEIGHT - BALL_SIZE) / 2);
    localparam logic [10:0] PY_C     = 11'((LCD_HEIGHT - PADDLE_H) / 2);
    localparam logic [11:0] PY_MAX   = 12'(LCD_HEIGHT - PADDLE_H);
    localparam logic [11:0] PSPD     = 12'(PADDLE_SPEED);
    localparam logic [10:0] BSZ      = 11'(BALL_SIZE);
    localparam logic [10:0] BSPD     = 11'(BALL_SPEED);
    localparam logic [10:0] PH       = 11'(PADDLE_H);
    localparam logic [10:0] LP_X0    = 11'(PADDLE_MARGIN);
    localparam logic [10:0] LP_X1    = 11'(PADDLE_MARGIN + PADDLE_W - 1);
    localparam logic [10:0] RP_X0    = 11'(LCD_WIDTH - PADDLE_MARGIN - PADDLE_W);
    localparam logic [10:0] RP_X1    = 11'(LCD_WIDTH - PADDLE_MARGIN - 1);
    localparam logic [10:0] L_HIT_LO = 11'(PADDLE_MARGIN + PADDLE_W - BALL_SPEED);
    localparam logic [10:0] L_HIT_HI = 11'(PADDLE_MARGIN + PADDLE_W);
    // Right-hand hit window is tested on the ball's right edge (bx+BALL_SIZE)
    // so it mirrors the left window about the screen centre.
    localparam logic [10:0] R_HIT_HI = 11'(LCD_WIDTH - PADDLE_MARGIN - PADDLE_W + BALL_SPEED);
    localparam logic [10:0] MISS_R   = 11'(LCD_WIDTH - BALL_SPEED);
    localparam logic [10:0] WALL_B   = 11'(LCD_HEIGHT - BALL_SPEED);
    localparam logic [10:0] NET_X0   = 11'(LCD_WIDTH / 2 - 1);
    localparam logic [10:0] NET_X1   = 11'(LCD_WIDTH / 2);
    localparam int          CW       = $clog2(SERVE_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {ST_SERVE, ST_PLAY, ST_POINT} state_t;

    state_t          state_q, state_d;
    logic            vs_prev_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [10:0]     bx_q, bx_d, by_q, by_d;
    logic            dx_q, dx_d, dy_q, dy_d;       // 1 = positive direction
    logic            serve_dx_q, serve_dx_d;
    logic [10:0]     pl_q, pl_d, pr_q, pr_d;
    logic [3:0]      score_l_q, score_l_d, score_r_q, score_r_d;
    logic [4:0]      red_q, red_d, blue_q, blue_d;
    logic [5:0]      green_q, green_d;
    logic            tick;
    logic            hit_ball, hit_paddle, hit_net;

    // Signed 12-bit arithmetic so a step past 0 shows up as negative
    // instead of wrapping to a large value.
    function automatic logic [10:0] paddle_next(input logic [10:0] y,
                                                input logic up, input logic dn);
        logic [11:0] t;
        paddle_next = y;
        if (dn && !up) begin
            t = {1'b0, y} + PSPD;
            paddle_next = ($signed(t) > $signed(PY_MAX)) ? PY_MAX[10:0] : t[10:0];
        end else if (up && !dn) begin
            t = {1'b0, y} - PSPD;
            paddle_next = ($signed(t) < 0) ? 11'd0 : t[10:0];
        end
    endfunction

    function automatic logic [3:0] score_inc(input logic [3:0] s);
        score_inc = (s == 4'd9) ? 4'd0 : s + 4'd1;
    endfunction

    function automatic logic overlaps(input logic [10:0] by, input logic [10:0] py);
        overlaps = (by < py + PH) && (by + BSZ > py);
    endfunction

    assign tick = LCD_VSYNC & ~vs_prev_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bx_d       = bx_q;
        by_d       = by_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        serve_dx_d = serve_dx_q;
        pl_d       = pl_q;
        pr_d       = pr_q;
        score_l_d  = score_l_q;
        score_r_d  = score_r_q;
        if (tick) begin
            pl_d = paddle_next(pl_q, BTN_L_UP, BTN_L_DN);
            pr_d = paddle_next(pr_q, BTN_R_UP, BTN_R_DN);
            case (state_q)
                ST_SERVE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (!dx_q && bx_q < BSPD) begin
                        score_r_d  = score_inc(score_r_q);
                        serve_dx_d = 1'b0;
                        state_d    = ST_POINT;
                    end else if (dx_q && (bx_q + BSZ > MISS_R)) begin
                        score_l_d  = score_inc(score_l_q);
                        serve_dx_d = 1'b1;
                        state_d    = ST_POINT;
                    end else begin
                        if (!dx_q && bx_q >= L_HIT_LO && bx_q <= L_HIT_HI && overlaps(by_q, pl_q))
                            dx_d = 1'b1;
                        if (dx_q && (bx_q + BSZ) >= RP_X0 && (bx_q + BSZ) <= R_HIT_HI
                            && overlaps(by_q, pr_q))
                            dx_d = 1'b0;
                        if (!dy_q && by_q < BSPD)
                            dy_d = 1'b1;
                        if (dy_q && (by_q + BSZ > WALL_B))
                            dy_d = 1'b0;
                        // Move with the post-bounce direction in the same tick.
                        bx_d = dx_d ? bx_q + BSPD : bx_q - BSPD;
                        by_d = dy_d ? by_q + BSPD : by_q - BSPD;
                    end
                end
                ST_POINT: begin
                    bx_d    = BX_C;
                    by_d    = BY_C;
                    dy_d    = 1'b1;
                    dx_d    = serve_dx_q;
                    state_d = ST_SERVE;
                end
                default: state_d = ST_SERVE;
            endcase
        end
    end

    // Pixel classification against the state latched at the last tick.
    assign hit_ball   = (X >= bx_q) && (X < bx_q + BSZ) && (Y >= by_q) && (Y < by_q + BSZ);
    assign hit_paddle = ((X >= LP_X0) && (X <= LP_X1) && (Y >= pl_q) && (Y < pl_q + PH)) ||
                        ((X >= RP_X0) && (X <= RP_X1) && (Y >= pr_q) && (Y < pr_q + PH));
    assign hit_net    = ((X == NET_X0) || (X == NET_X1)) && !Y[3];

    always_comb begin
        red_d   = 5'd0;
        green_d = 6'd0;
        blue_d  = 5'd0;
        if (LCD_DEN) begin
            if (hit_ball || hit_paddle) begin
                red_d   = 5'd31;
                green_d = 6'd63;
                blue_d  = 5'd31;
            end else if (hit_net) begin
                red_d   = 5'd15;
                green_d = 6'd31;
                blue_d  = 5'd15;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_IN) begin
            vs_prev_q  <= 1'b1;
            state_q    <= ST_SERVE;
            cnt_q      <= '0;
            bx_q       <= BX_C;
            by_q       <= BY_C;
            dx_q       <= 1'b1;
            dy_q       <= 1'b1;
            serve_dx_q <= 1'b1;
            pl_q       <= PY_C;
            pr_q       <= PY_C;
            score_l_q  <= 4'd0;
            score_r_q  <= 4'd0;
            red_q      <= 5'd0;
            green_q    <= 6'd0;
            blue_q     <= 5'd0;
        end else begin
            vs_prev_q  <= LCD_VSYNC;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            serve_dx_q <= serve_dx_d;
            pl_q       <= pl_d;
            pr_q       <= pr_d;
            score_l_q  <= score_l_d;
            score_r_q  <= score_r_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
        end
    end

    assign RED     = red_q;
    assign GREEN   = green_q;
    assign BLUE    = blue_q;
    assign SCORE_L = score_l_q;
    assign SCORE_R = score_r_q;

endmodule

// File: tb/tb_pong_game_render.sv
// Directed bench for pong_game_render: game state is observed through the
// rendered pixels and the score outputs.
module tb_pong_game_render;
    logic        CLK = 1'b0;
    logic        RST_IN = 1'b0;
    logic        LCD_DEN = 1'b0;
    logic        LCD_VSYNC = 1'b1;
    logic [10:0] X = '0;
    logic [10:0] Y = '0;
    logic        BTN_L_UP = 1'b0, BTN_L_DN = 1'b0, BTN_R_UP = 1'b0, BTN_R_DN = 1'b0;
    logic [4:0]  RED, BLUE;
    logic [5:0]  GREEN;
    logic [3:0]  SCORE_L, SCORE_R;

    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] GREY  = {5'd15, 6'd31, 5'd15};
    localparam logic [15:0] BLACK = 16'h0000;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [15:0] rgb;

    pong_game_render dut (
        .CLK(CLK), .RST_IN(RST_IN), .LCD_DEN(LCD_DEN), .LCD_VSYNC(LCD_VSYNC),
        .X(X), .Y(Y),
        .BTN_L_UP(BTN_L_UP), .BTN_L_DN(BTN_L_DN), .BTN_R_UP(BTN_R_UP), .BTN_R_DN(BTN_R_DN),
        .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .SCORE_L(SCORE_L), .SCORE_R(SCORE_R)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        RST_IN = 1'b1;
        @(posedge CLK); #1;
        RST_IN = 1'b0;
    endtask

    // One frame: VSYNC low for a cycle, then high; the rising edge is one tick.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            LCD_VSYNC = 1'b0; @(posedge CLK); #1;
            LCD_VSYNC = 1'b1; @(posedge CLK); #1;
        end
    endtask

    // Present one active pixel and capture the registered colour one cycle later.
    task automatic probe(input int px, input int py);
        X = 11'(px); Y = 11'(py); LCD_DEN = 1'b1;
        @(posedge CLK); #1;
        rgb = {RED, GREEN, BLUE};
        LCD_DEN = 1'b0;
    endtask

    task automatic test_reset();
        X = 11'd240; Y = 11'd140; LCD_DEN = 1'b1;
        RST_IN = 1'b1;
        @(posedge CLK); #1;
        total_cnt++; if ({RED, GREEN, BLUE} !== BLACK) $display("FAIL reset_rgb: got %h expected %h", {RED, GREEN, BLUE}, BLACK); else begin pass_cnt++; $display("ok reset_rgb %h", {RED, GREEN, BLUE}); end
        RST_IN = 1'b0; LCD_DEN = 1'b0;
        total_cnt++; if ({SCORE_L, SCORE_R} !== 8'h00) $display("FAIL reset_scores: got %h expected 00", {SCORE_L, SCORE_R}); else begin pass_cnt++; $display("ok reset_scores"); end
    endtask

    task automatic test_pixels();
        probe(240, 140);
        total_cnt++; if (rgb !== WHITE) $display("FAIL pix_ball: got %h expected %h", rgb, WHITE); else begin pass_cnt++; $display("ok pix_ball %h", rgb); end
        probe(240, 144);
        total_cnt++; if (rgb !== GREY) $display("FAIL pix_net_on: got %h expected %h", rgb, GREY); else begin pass_cnt++; $display("ok pix_net_on %h", rgb); end
        probe(239, 144);
        total_cnt++; if (rgb !== GREY) $display("FAIL pix_net_239: got %h expected %h", rgb, GREY); else begin pass_cnt++; $display("ok pix_net_239 %h", rgb); end
        probe(240, 152);
        total_cnt++; if (rgb !== BLACK) $display("FAIL pix_net_gap: got %h expected %h", rgb, BLACK); else begin pass_cnt++; $display("ok pix_net_gap %h", rgb); end
        probe(10, 116);
        total_cnt++; if (rgb !== WHITE) $display("FAIL pix_lpaddle: got %h expected %h", rgb, WHITE); else begin pass_cnt++; $display("ok pix_lpaddle %h", rgb); end
        probe(14, 116);
        total_cnt++; if (rgb !== BLACK) $display("FAIL pix_lpaddle_edge: got %h expected %h", rgb, BLACK); else begin pass_cnt++; $display("ok pix_lpaddle_edge %h", rgb); end
        X = 11'd240; Y = 11'd140; LCD_DEN = 1'b0;
        @(posedge CLK); #1;
        total_cnt++; if ({RED, GREEN, BLUE} !== BLACK) $display("FAIL pix_den_low: got %h expected %h", {RED, GREEN, BLUE}, BLACK); else begin pass_cnt++; $display("ok pix_den_low"); end
    endtask

    task automatic test_left_paddle();
        do_reset();
        BTN_L_UP = 1'b1;
        frames(28);                       // y = 116 - 112 = 4
        probe(10, 4);
        total_cnt++; if (rgb !== WHITE) $display("FAIL lpad_y4_top: got %h expected %h", rgb, WHITE); else begin pass_cnt++; $display("ok lpad_y4_top"); end
        probe(10, 3);
        total_cnt++; if (rgb !== BLACK) $display("FAIL lpad_y4_above: got %h expected %h", rgb, BLACK); else begin pass_cnt++; $display("ok lpad_y4_above"); end
        frames(1);                        // y = 0
        probe(10, 0);
        total_cnt++; if (rgb !== WHITE) $display("FAIL lpad_y0_top: got %h expected %h", rgb, WHITE); else begin pass_cnt++; $display("ok lpad_y0_top"); end
        probe(10, 47);
        total_cnt++; if (rgb !== WHITE) $display("FAIL lpad_y0_last: got %h expected %h", rgb, WHITE); else begin pass_cnt++; $display("ok lpad_y0_last"); end
        frames(11);                       // clamped at 0
        probe(10, 0);
        total_cnt++; if (rgb !== WHITE) $display("FAIL lpad_clamp_top: got %h expected %h", rgb, WHITE); else begin pass_cnt++; $display("ok lpad_clamp_top"); end
        probe(10, 48);
        total_cnt++; if (rgb !== BLACK) $display("FAIL lpad_clamp_below: got %h expected %h", rgb, BLACK); else begin pass_cnt++; $display("ok lpad_clamp_below"); end
        BTN_L_UP = 1'b0;
    endtask

    task automatic test_right_paddle();
        do_reset();
        BTN_R_UP = 1'b1; BTN_R_DN = 1'b1;
        frames(10);                       // both pressed: hold at 116
        probe(468, 116);
        total_cnt++; if (rgb !== WHITE) $display("FAIL rpad_hold_top: got %h expected %h", rgb, WHITE); else begin pass_cnt++; $display("ok rpad_hold_top"); end
        probe(468, 115);
        total_cnt++; if (rgb !== BLACK) $display("FAIL rpad_hold_above: got %h expected %h", rgb, BLACK); else begin pass_cnt++; $display("ok rpad_hold_above"); end
        probe(468, 164);
        total_cnt++; if (rgb !== BLACK) $display("FAIL rpad_hold_below: got %h expected %h", rgb, BLACK); else begin pass_cnt++; $display("ok rpad_hold_below"); end
        BTN_R_UP = 1'b0;
        frames(40);                       // clamps at 232
        probe(471, 279);
        total_cnt++; if (rgb !== WHITE) $display("FAIL rpad_clamp_bot: got %h expected %h", rgb, WHITE); else begin pass_cnt++; $display("ok rpad_clamp_bot"); end
        probe(471, 231);
        total_cnt++; if (rgb !== BLACK) $display("FAIL rpad_clamp_above: got %h expected %h", rgb, BLACK); else begin pass_cnt++; $display("ok rpad_clamp_above"); end
        probe(472, 240);
        total_cnt++; if (rgb !== BLACK) $display("FAIL rpad_x_edge: got %h expected %h", rgb, BLACK); else begin pass_cnt++; $display("ok rpad_x_edge"); end
        BTN_R_DN = 1'b0;
    endtask

    task automatic test_serve_play();
        do_reset();
        frames(60);                       // serve done, ball not yet moved
        probe(236, 136);
        total_cnt++; if (rgb !== WHITE) $display("FAIL serve_centre: got %h expected %h", rgb, WHITE); else begin pass_cnt++; $display("ok serve_centre"); end
        probe(244, 136);
        total_cnt++; if (rgb !== BLACK) $display("FAIL serve_centre_right: got %h expected %h", rgb, BLACK); else begin pass_cnt++; $display("ok serve_centre_right"); end
        frames(1);                        // first move to (238,138)
        probe(238, 138);
        total_cnt++; if (rgb !== WHITE) $display("FAIL play_first_move: got %h expected %h", rgb, WHITE); else begin pass_cnt++; $display("ok play_first_move"); end
        probe(237, 138);
        total_cnt++; if (rgb !== BLACK) $display("FAIL play_first_left: got %h expected %h", rgb, BLACK); else begin pass_cnt++; $display("ok play_first_left"); end
        frames(67);                       // 68 moves: ball at (372,272)
        probe(372, 272);
        total_cnt++; if (rgb !== WHITE) $display("FAIL play_bottom: got %h expected %h", rgb, WHITE); else begin pass_cnt++; $display("ok play_bottom"); end
        probe(372, 271);
        total_cnt++; if (rgb !== BLACK) $display("FAIL play_bottom_above: got %h expected %h", rgb, BLACK); else begin pass_cnt++; $display("ok play_bottom_above"); end
        frames(1);                        // bounce and move: (374,270)
        probe(381, 277);
        total_cnt++; if (rgb !== WHITE) $display("FAIL bounce_corner: got %h expected %h", rgb, WHITE); else begin pass_cnt++; $display("ok bounce_corner"); end
        probe(374, 278);
        total_cnt++; if (rgb !== BLACK) $display("FAIL bounce_below: got %h expected %h", rgb, BLACK); else begin pass_cnt++; $display("ok bounce_below"); end
    endtask

    // Right paddle parked at y=160 returns the ball at PLAY tick 112; the ball
    // then misses the left paddle (y=0) and scores for the right on PLAY tick 341.
    task automatic test_score();
        int n;
        do_reset();
        BTN_L_UP = 1'b1; BTN_R_DN = 1'b1;
        frames(11);
        BTN_R_DN = 1'b0;
        frames(18);
        BTN_L_UP = 1'b0;
        probe(468, 160);
        total_cnt++; if (rgb !== WHITE) $display("FAIL score_rpad_160: got %h expected %h", rgb, WHITE); else begin pass_cnt++; $display("ok score_rpad_160"); end
        frames(31);                       // 60 serve ticks total -> PLAY
        n = 0;
        while (SCORE_R == 4'd0 && n < 400) begin
            frames(1);
            n++;
        end
        total_cnt++; if (n != 341) $display("FAIL score_tick: got %0d expected 341", n); else begin pass_cnt++; $display("ok score_tick %0d", n); end
        total_cnt++; if (SCORE_R !== 4'd1) $display("FAIL score_r: got %0d expected 1", SCORE_R); else begin pass_cnt++; $display("ok score_r"); end
        total_cnt++; if (SCORE_L !== 4'd0) $display("FAIL score_l: got %0d expected 0", SCORE_L); else begin pass_cnt++; $display("ok score_l"); end
        frames(1);                        // POINT -> SERVE, recentred
        probe(236, 136);
        total_cnt++; if (rgb !== WHITE) $display("FAIL point_recentre: got %h expected %h", rgb, WHITE); else begin pass_cnt++; $display("ok point_recentre"); end
        frames(61);                       // serve, then first move with dx negative
        probe(234, 138);
        total_cnt++; if (rgb !== WHITE) $display("FAIL serve_dir_left: got %h expected %h", rgb, WHITE); else begin pass_cnt++; $display("ok serve_dir_left"); end
        probe(242, 138);
        total_cnt++; if (rgb !== BLACK) $display("FAIL serve_dir_edge: got %h expected %h", rgb, BLACK); else begin pass_cnt++; $display("ok serve_dir_edge"); end
    endtask

    // Reset lands on a cycle that would otherwise be a tick; afterwards the
    // serve must still last the full 60 ticks.
    task automatic test_mid_reset();
        frames(5);
        LCD_VSYNC = 1'b0; @(posedge CLK); #1;
        X = 11'd236; Y = 11'd136; LCD_DEN = 1'b1;
        LCD_VSYNC = 1'b1; RST_IN = 1'b1;
        @(posedge CLK); #1;
        RST_IN = 1'b0; LCD_DEN = 1'b0;
        total_cnt++; if ({RED, GREEN, BLUE} !== BLACK) $display("FAIL mid_reset_rgb: got %h expected %h", {RED, GREEN, BLUE}, BLACK); else begin pass_cnt++; $display("ok mid_reset_rgb"); end
        total_cnt++; if ({SCORE_L, SCORE_R} !== 8'h00) $display("FAIL mid_reset_scores: got %h expected 00", {SCORE_L, SCORE_R}); else begin pass_cnt++; $display("ok mid_reset_scores"); end
        probe(236, 136);
        total_cnt++; if (rgb !== WHITE) $display("FAIL mid_reset_centre: got %h expected %h", rgb, WHITE); else begin pass_cnt++; $display("ok mid_reset_centre"); end
        frames(60);
        probe(236, 136);
        total_cnt++; if (rgb !== WHITE) $display("FAIL mid_reset_no_tick: got %h expected %h", rgb, WHITE); else begin pass_cnt++; $display("ok mid_reset_no_tick"); end
        frames(1);
        probe(245, 145);
        total_cnt++; if (rgb !== WHITE) $display("FAIL mid_reset_play: got %h expected %h", rgb, WHITE); else begin pass_cnt++; $display("ok mid_reset_play"); end
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_pixels();
        test_left_paddle();
        test_right_paddle();
        test_serve_play();
        test_score();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
